fp16_tree_encoder: RTL and testbench
====================================

FP16_TREE_ENCODER -- requirements
Module: fp16_tree_encoder

Interface
REQ-001 SHALL have parameter TreeDepth, default 4, number of tree levels (legal range 1..6).
REQ-002 SHALL have parameter NumNodes, fixed at 2^TreeDepth-1, the number of threshold registers.
REQ-003 SHALL have port clk_i  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port thr_we_i  input  1  threshold write enable.
REQ-006 SHALL have port thr_addr_i  input  TreeDepth  threshold node index.
REQ-007 SHALL have port thr_data_i  input  16  FP16 threshold value.
REQ-008 SHALL have port in_valid_i  input  1  feature vector valid.
REQ-009 SHALL have port in_ready_o  output  1  encoder accepts a feature vector.
REQ-010 SHALL have port in_feat_i  input  16*TreeDepth  FP16 feature for level l at bits [16l+15:16l].
REQ-011 SHALL have port out_valid_o  output  1  encoded index valid.
REQ-012 SHALL have port out_ready_i  input  1  downstream accepts the index.
REQ-013 SHALL have port out_idx_o  output  TreeDepth  leaf (prototype) index.
REQ-014 SHALL have port busy_o  output  1  high in WALK or DONE.

Function
REQ-015 SHALL hold NumNodes 16-bit threshold registers; write on edge when thr_we_i=1 and thr_addr_i<NumNodes; addr=NumNodes ignored.
REQ-016 SHALL number nodes root=0, left child 2n+1, right child 2n+2.
REQ-017 SHALL go right iff feature > threshold (strict), else left.
REQ-018 SHALL order FP16 by sign-magnitude: positive > negative; both positive, larger {exp,mant} greater; both negative, smaller {exp,mant} greater; identical patterns not greater; +0 > -0; no NaN/Inf special-casing.
REQ-019 SHALL implement FSM IDLE, WALK, DONE.
REQ-020 IDLE: in_ready_o=1; on in_valid_i&in_ready_o capture in_feat_i into a feature register, node=0, level=0, go WALK.
REQ-021 WALK: each cycle compare feature[level] with threshold[node], update node to its child, level++; after TreeDepth compares go DONE.
REQ-022 DONE: out_valid_o=1, out_idx_o = final node - NumNodes (decision bits MSB=root); stay until out_ready_i=1, then IDLE.
REQ-023 Latency: handshake on edge k -> out_valid_o high after edge k+TreeDepth; minimum accept interval TreeDepth+2 cycles.
REQ-024 in_ready_o SHALL be 0 in WALK and DONE; in_valid_i there SHALL be ignored.
REQ-025 out_idx_o and out_valid_o SHALL be stable while out_valid_o=1 and out_ready_i=0.
REQ-026 out_idx_o SHALL hold last result outside DONE; in_feat_i changes after capture SHALL not affect the result.
REQ-027 Threshold write concurrent with a WALK compare on the same node: compare SHALL use the pre-write value; later compares see the new value.
REQ-028 Writes SHALL be accepted in every state.

Reset
REQ-029 rst_i=1 SHALL immediately force IDLE, out_valid_o=0, out_idx_o=0, busy_o=0, thresholds and feature register to 0x0000.
REQ-030 Reset mid-WALK or mid-DONE SHALL abort with no output; in_ready_o=1 on first cycle after rst_i deasserts.

Verification (TreeDepth=4)
REQ-031 Reset, thresholds 0x0000, features all 0x3C00 -> out_idx_o=15 four cycles after accept.
REQ-032 Thresholds 0x0000, features all 0xBC00 -> out_idx_o=0.
REQ-033 Thresholds all 0x3C00, features all 0x3C00 -> out_idx_o=0 (equality goes left).
REQ-034 thr[0]=0xC000, thr[2]=0x8000, thr[6]=0x4000, thr[13]=0x3C00; feat={0xBC00,0x0000,0x3C00,0x3C01} (level 0..3) -> R,R,L,R -> out_idx_o=13.
REQ-035 out_ready_i low 5 cycles in DONE with in_valid_i=1 -> out_valid_o/out_idx_o held, in_ready_o=0, nothing accepted; out_ready_i=1 -> IDLE next cycle.
REQ-036 rst_i pulsed in 2nd WALK cycle -> out_valid_o never asserts, thresholds read back as 0 (REQ-032 gives idx 0 for negative features, REQ-031 idx 15).

Source files
------------

// File: rtl/fp16_tree_encoder.sv
// fp16_tree_encoder: walks a complete binary decision tree of FP16 thresholds
// one level per clock and returns the reached leaf as a prototype index.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   thr_we_i/addr_i/data_i  threshold register write (accepted in any state)
//   in_valid_i/in_ready_o   feature-vector handshake
//   in_feat_i             TreeDepth packed FP16 features, level l at [16l+15:16l]
//   out_valid_o/out_ready_i result handshake
//   out_idx_o             leaf index, decision bits with the root decision as MSB
//   busy_o                high while walking or holding a result
module fp16_tree_encoder #(
    parameter int unsigned TreeDepth = 4,
    parameter int unsigned NumNodes  = (1 << TreeDepth) - 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      thr_we_i,
    input  logic [TreeDepth-1:0]      thr_addr_i,
    input  logic [15:0]               thr_data_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [16*TreeDepth-1:0]   in_feat_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [TreeDepth-1:0]      out_idx_o,
    output logic                      busy_o
);

    localparam int unsigned FeatW  = 16 * TreeDepth;
    localparam int unsigned NodeW  = TreeDepth + 1;
    localparam int unsigned LevelW = $clog2(TreeDepth + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [15:0]          thr_q [NumNodes];
    logic [FeatW-1:0]     feat_q;
    logic [TreeDepth-1:0] node_q;
    logic [LevelW-1:0]    level_q;
    logic [TreeDepth-1:0] idx_q;

    logic [15:0]          cur_feat;
    logic [15:0]          cur_thr;
    logic                 go_right;
    logic                 last_level;
    logic [NodeW-1:0]     child;
    logic [TreeDepth-1:0] leaf;

    // Sign-magnitude ordering: a > b strictly; +0 > -0, no NaN/Inf handling.
    function automatic logic fp16_gt(input logic [15:0] a, input logic [15:0] b);
        logic gt;
        if (a[15] != b[15]) begin
            gt = b[15];
        end else if (!a[15]) begin
            gt = a[14:0] > b[14:0];
        end else begin
            gt = a[14:0] < b[14:0];
        end
        return gt;
    endfunction

    // Current-level compare and child selection (reads pre-write threshold value).
    always_comb begin
        cur_feat   = feat_q[16*32'(level_q) +: 16];
        cur_thr    = thr_q[node_q];
        go_right   = fp16_gt(cur_feat, cur_thr);
        last_level = (level_q == LevelW'(TreeDepth - 1));
        child      = {node_q, 1'b0} + NodeW'(1) + NodeW'(go_right);
        leaf       = TreeDepth'(child - NodeW'(NumNodes));
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid_i) state_d = WALK;
            WALK: if (last_level) state_d = DONE;
            DONE: if (out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Feature capture, tree walk and result register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            feat_q  <= '0;
            node_q  <= '0;
            level_q <= '0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        feat_q  <= in_feat_i;
                        node_q  <= '0;
                        level_q <= '0;
                    end
                end
                WALK: begin
                    node_q  <= child[TreeDepth-1:0];
                    level_q <= level_q + LevelW'(1);
                    if (last_level) begin
                        idx_q <= leaf;
                    end
                end
                default: ;
            endcase
        end
    end

    // Threshold registers; the out-of-range address NumNodes is dropped.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NumNodes); i++) begin
                thr_q[i] <= 16'h0000;
            end
        end else if (thr_we_i && (32'(thr_addr_i) < NumNodes)) begin
            thr_q[thr_addr_i] <= thr_data_i;
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);
    assign out_idx_o   = idx_q;

endmodule

// File: tb/tb_fp16_tree_encoder.sv
// Self-checking bench for fp16_tree_encoder with TreeDepth=4.
module tb_fp16_tree_encoder;

    logic        clk;
    logic        rst;
    logic        thr_we;
    logic [3:0]  thr_addr;
    logic [15:0] thr_data;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_feat;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_idx;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    logic [3:0] exp_q[$];

    fp16_tree_encoder #(.TreeDepth(4)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .thr_we_i   (thr_we),
        .thr_addr_i (thr_addr),
        .thr_data_i (thr_data),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_feat_i  (in_feat),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_idx_o  (out_idx),
        .busy_o     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_thr(input logic [3:0] addr, input logic [15:0] data);
        thr_we = 1'b1; thr_addr = addr; thr_data = data;
        tick();
        thr_we = 1'b0;
    endtask

    task automatic write_all(input logic [15:0] data);
        for (int i = 0; i < 15; i++) write_thr(4'(i), data);
    endtask

    // Accept one vector; afterwards the input bus is scrambled to prove capture.
    task automatic accept(input string tag, input logic [63:0] feat, input logic [3:0] exp_idx);
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        in_feat = feat; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_feat  = {$urandom, $urandom};
        exp_q.push_back(exp_idx);
    endtask

    // Wait (bounded) for the result, check latency and index against the scoreboard.
    task automatic wait_out(input string tag, output logic [3:0] got_exp);
        int cnt = 0;
        while (!out_valid && cnt < 20) begin
            tick();
            thr_we = 1'b0;
            cnt++;
            if (cnt == 2) check({tag, "_walk_busy"}, {30'd0, busy, in_ready}, 32'h2);
        end
        check({tag, "_latency"}, 32'(cnt), 32'd4);
        if (exp_q.size() == 0) begin
            got_exp = 4'hx;
            check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
        end else begin
            got_exp = exp_q.pop_front();
            check({tag, "_idx"}, 32'(out_idx), 32'(got_exp));
        end
    endtask

    task automatic run(input string tag, input logic [63:0] feat, input logic [3:0] exp_idx);
        logic [3:0] e;
        accept(tag, feat, exp_idx);
        wait_out(tag, e);
        tick();
        check({tag, "_back_idle"}, {30'd0, out_valid, in_ready}, 32'h1);
    endtask

    initial begin
        logic [3:0] e;
        rst = 1'b1; thr_we = 1'b0; thr_addr = '0; thr_data = '0;
        in_valid = 1'b0; in_feat = '0; out_ready = 1'b1;
        tick(); tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_idx",   32'(out_idx),   32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        rst = 1'b0;
        tick();

        // Zero thresholds: positive features all right, negative all left.
        run("pos_all", {4{16'h3C00}}, 4'd15);
        run("neg_all", {4{16'hBC00}}, 4'd0);

        // Equality goes left; out-of-range address is dropped.
        write_all(16'h3C00);
        write_thr(4'd15, 16'h7BFF);
        run("equal", {4{16'h3C00}}, 4'd0);

        // Mixed path R,R,L,R.
        write_thr(4'd0,  16'hC000);
        write_thr(4'd2,  16'h8000);
        write_thr(4'd6,  16'h4000);
        write_thr(4'd13, 16'h3C00);
        run("path13", {16'h3C01, 16'h3C00, 16'h0000, 16'hBC00}, 4'd13);

        // Backpressure in DONE with in_valid asserted.
        out_ready = 1'b0;
        accept("bp", {4{16'h3C00}}, 4'd12);
        wait_out("bp", e);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_state", {29'd0, out_valid, in_ready, busy}, 32'h5);
            check("bp_hold_idx",   32'(out_idx), 32'(e));
        end
        out_ready = 1'b1; in_valid = 1'b0;
        tick();
        check("bp_release", {30'd0, out_valid, in_ready}, 32'h1);
        check("bp_idx_kept", 32'(out_idx), 32'(e));
        tick();
        check("bp_nothing_taken", {31'd0, busy}, 32'd0);

        // Write to node 0 on the same edge as its compare: old value C000 used.
        accept("cw", {4{16'h3C00}}, 4'd12);
        thr_we = 1'b1; thr_addr = 4'd0; thr_data = 16'h7000;
        wait_out("cw", e);
        tick();
        run("cw_after", {4{16'h3C00}}, 4'd0);

        // Reset in the second WALK cycle aborts the walk and clears thresholds.
        accept("mid_rst", {4{16'h3C00}}, 4'd0);
        void'(exp_q.pop_back());
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_state", {29'd0, out_valid, in_ready, busy}, 32'h2);
        check("mid_rst_idx",   32'(out_idx), 32'd0);
        tick();
        rst = 1'b0;
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("mid_rst_no_out", 32'(out_valid), 32'd0);
        end
        run("post_rst_neg", {4{16'hBC00}}, 4'd0);
        run("post_rst_pos", {4{16'h3C00}}, 4'd15);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
